// File: rtl/tlp_length_tracker_if.sv
// Beat bus into and out of tlp_length_tracker: the source drives through master, the tracker sits on slave.
// The outputs are the registered pass-through copies of the beat plus the per-slot lengths and error pulses.
interface tlp_length_tracker_if #(
    parameter int DATA_BYTES = 64,
    parameter int MAX_PKTS   = 4,
    parameter int LEN_W      = 11
);
    logic [2:0]                gen;
    logic [8*DATA_BYTES-1:0]   data_in;
    logic                      wr;
    logic [DATA_BYTES-1:0]     wr_valid;
    logic [DATA_BYTES-1:0]     STP_IN;
    logic [DATA_BYTES-1:0]     SDP_IN;
    logic [DATA_BYTES-1:0]     END_IN;

    logic [8*DATA_BYTES-1:0]   data_out;
    logic                      wr_out;
    logic [DATA_BYTES-1:0]     wr_valid_out;
    logic [DATA_BYTES-1:0]     STP_out;
    logic [DATA_BYTES-1:0]     SDP_out;
    logic [DATA_BYTES-1:0]     END_out;
    logic [MAX_PKTS*LEN_W-1:0] length;
    logic [MAX_PKTS-1:0]       length_valid;
    logic                      in_pkt;
    logic [3:0]                err;

    modport master (
        output gen, data_in, wr, wr_valid, STP_IN, SDP_IN, END_IN,
        input  data_out, wr_out, wr_valid_out, STP_out, SDP_out, END_out,
        input  length, length_valid, in_pkt, err
    );

    modport slave (
        input  gen, data_in, wr, wr_valid, STP_IN, SDP_IN, END_IN,
        output data_out, wr_out, wr_valid_out, STP_out, SDP_out, END_out,
        output length, length_valid, in_pkt, err
    );
endinterface

// File: rtl/tlp_length_tracker.sv
// Measures TLP length in DWs from STP to END across beats; 1-cycle registered latency, no backpressure.
// LENGTH_TRACKER_ERR_EN enables the {sat, drop, restart, misalign} pulses on err; otherwise err is tied to 0.
module tlp_length_tracker #(
    parameter int DATA_BYTES = 64,
    parameter int MAX_PKTS   = 4,
    parameter int LEN_W      = 11
) (
    input  logic                 pclk,
    input  logic                 reset,
    tlp_length_tracker_if.slave  bus
);
    localparam int CNT_W = LEN_W + 2;

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          run_cnt_q, run_cnt_d;
    logic [8*DATA_BYTES-1:0]   data_out_q, data_out_d;
    logic                      wr_out_q, wr_out_d;
    logic [DATA_BYTES-1:0]     wr_valid_out_q, wr_valid_out_d;
    logic [DATA_BYTES-1:0]     stp_out_q, stp_out_d;
    logic [DATA_BYTES-1:0]     sdp_out_q, sdp_out_d;
    logic [DATA_BYTES-1:0]     end_out_q, end_out_d;
    logic [MAX_PKTS*LEN_W-1:0] length_q, length_d;
    logic [MAX_PKTS-1:0]       length_valid_q, length_valid_d;
    logic                      in_pkt_q, in_pkt_d;
    logic                      gen_ok;
    int                        slot;
`ifdef LENGTH_TRACKER_ERR_EN
    logic                      sat_pend_q, sat_pend_d;
    logic [3:0]                err_q, err_d;
`endif

    assign gen_ok = bus.gen inside {3'd3, 3'd4, 3'd5};

    always_comb begin
        state_d        = state_q;
        run_cnt_d      = run_cnt_q;
        length_d       = '0;
        length_valid_d = '0;
        slot           = 0;
        data_out_d     = bus.data_in;
        wr_out_d       = bus.wr;
        wr_valid_out_d = bus.wr_valid;
        stp_out_d      = bus.STP_IN;
        sdp_out_d      = bus.SDP_IN;
        end_out_d      = bus.END_IN;
`ifdef LENGTH_TRACKER_ERR_EN
        sat_pend_d     = sat_pend_q;
        err_d          = '0;
`endif
        if (!gen_ok) begin
            state_d   = IDLE;
            run_cnt_d = '0;
`ifdef LENGTH_TRACKER_ERR_EN
            sat_pend_d = 1'b0;
`endif
        end else if (bus.wr) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (bus.wr_valid[i]) begin
                    if (bus.STP_IN[i]) begin
`ifdef LENGTH_TRACKER_ERR_EN
                        if (state_d == IN_PKT) err_d[1] = 1'b1;
                        sat_pend_d = 1'b0;
`endif
                        state_d   = IN_PKT;
                        run_cnt_d = CNT_W'(1);
                    end else if (state_d == IN_PKT) begin
                        // Count clamps at all-ones; the packet remembers it lost bytes.
`ifdef LENGTH_TRACKER_ERR_EN
                        if (run_cnt_d == '1) sat_pend_d = 1'b1;
`endif
                        if (run_cnt_d != '1) run_cnt_d = run_cnt_d + CNT_W'(1);
                    end

                    if (bus.END_IN[i] && state_d == IN_PKT) begin
                        for (int k = 0; k < MAX_PKTS; k++) begin
                            if (k == slot) begin
                                length_d[k*LEN_W +: LEN_W] = run_cnt_d[CNT_W-1:2];
                                length_valid_d[k]          = 1'b1;
                            end
                        end
`ifdef LENGTH_TRACKER_ERR_EN
                        if (slot >= MAX_PKTS) err_d[2] = 1'b1;
                        // A saturated count says nothing about alignment.
                        if (sat_pend_d) err_d[3] = 1'b1;
                        else if (run_cnt_d[1:0] != 2'b00) err_d[0] = 1'b1;
                        sat_pend_d = 1'b0;
`endif
                        slot    = slot + 1;
                        state_d = IDLE;
                    end
                end
            end
        end
        in_pkt_d = (state_d == IN_PKT);
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            run_cnt_q      <= '0;
            data_out_q     <= '0;
            wr_out_q       <= 1'b0;
            wr_valid_out_q <= '0;
            stp_out_q      <= '0;
            sdp_out_q      <= '0;
            end_out_q      <= '0;
            length_q       <= '0;
            length_valid_q <= '0;
            in_pkt_q       <= 1'b0;
`ifdef LENGTH_TRACKER_ERR_EN
            sat_pend_q     <= 1'b0;
            err_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            run_cnt_q      <= run_cnt_d;
            data_out_q     <= data_out_d;
            wr_out_q       <= wr_out_d;
            wr_valid_out_q <= wr_valid_out_d;
            stp_out_q      <= stp_out_d;
            sdp_out_q      <= sdp_out_d;
            end_out_q      <= end_out_d;
            length_q       <= length_d;
            length_valid_q <= length_valid_d;
            in_pkt_q       <= in_pkt_d;
`ifdef LENGTH_TRACKER_ERR_EN
            sat_pend_q     <= sat_pend_d;
            err_q          <= err_d;
`endif
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.wr_out       = wr_out_q;
    assign bus.wr_valid_out = wr_valid_out_q;
    assign bus.STP_out      = stp_out_q;
    assign bus.SDP_out      = sdp_out_q;
    assign bus.END_out      = end_out_q;
    assign bus.length       = length_q;
    assign bus.length_valid = length_valid_q;
    assign bus.in_pkt       = in_pkt_q;
`ifdef LENGTH_TRACKER_ERR_EN
    assign bus.err          = err_q;
`else
    assign bus.err          = 4'b0;
`endif
endmodule
